// File: rtl/calc2_port_if.sv
// Request/response bundle for one calc2 port. The requester (master) drives req_*; the engine (slave) drives out_* and tag_err.
// Handshake: there is no ready. A nonzero req_cmd_in is taken whenever the engine is idle, and operand 2 is taken on the next cycle. Responses are single-cycle pulses.
interface calc2_port_if;
    logic [3:0]  req_cmd_in;
    logic [31:0] req_data_in;
    logic [1:0]  req_tag_in;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic [1:0]  out_tag;
    logic        tag_err;

    modport master (
        output req_cmd_in, req_data_in, req_tag_in,
        input  out_resp, out_data, out_tag, tag_err
    );

    modport slave (
        input  req_cmd_in, req_data_in, req_tag_in,
        output out_resp, out_data, out_tag, tag_err
    );
endinterface

// File: rtl/calc2_port_engine.sv
// Single-port calc2 execution slice: two-cycle request capture, per-tag busy tracking,
// a 2-stage add/sub path, a 4-stage shift path and a one-entry skid for output collisions.
module calc2_port_engine (
    input  logic        c_clk,
    input  logic        reset,
    calc2_port_if.slave bus,
    output logic        state_dbg
);
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;
    localparam logic [1:0] RESP_OK  = 2'd1;
    localparam logic [1:0] RESP_ERR = 2'd2;

    typedef enum logic {S_IDLE = 1'b0, S_OP2 = 1'b1} state_t;

    state_t      state;
    logic [3:0]  cmd_q;
    logic [1:0]  tag_q;
    logic [31:0] op1_q;
    logic [3:0]  busy;

    logic        as1_v;
    logic [3:0]  as1_cmd;
    logic [1:0]  as1_tag;
    logic [31:0] as1_op1;
    logic [31:0] as1_op2;
    logic        as2_v;
    logic [1:0]  as2_resp;
    logic [1:0]  as2_tag;
    logic [31:0] as2_data;

    logic [3:0]  sh_v;
    logic [1:0]  sh_tag [4];
    logic [31:0] sh_data [4];
    logic        skid_v;
    logic [1:0]  skid_tag;
    logic [31:0] skid_data;

    logic        issue;
    logic        is_shift;
    logic [31:0] shift_res;
    logic [32:0] sum33;
    logic [1:0]  as_resp_c;
    logic [31:0] as_data_c;
    logic        sel_v;
    logic [1:0]  sel_resp;
    logic [1:0]  sel_tag;
    logic [31:0] sel_data;
    logic        skid_load;
    logic [3:0]  busy_set;
    logic [3:0]  busy_clr;

    assign state_dbg = (state == S_OP2);
    assign issue     = (state == S_OP2) && !busy[tag_q];
    assign is_shift  = (cmd_q == CMD_SHL) || (cmd_q == CMD_SHR);
    assign shift_res = (cmd_q == CMD_SHL) ? (op1_q << bus.req_data_in[4:0])
                                          : (op1_q >> bus.req_data_in[4:0]);
    assign sum33     = {1'b0, as1_op1} + {1'b0, as1_op2};

    // Invalid commands share the add/sub path and always come back as errors.
    always_comb begin
        as_resp_c = RESP_ERR;
        as_data_c = 32'd0;
        case (as1_cmd)
            CMD_ADD: if (!sum33[32]) begin
                as_resp_c = RESP_OK;
                as_data_c = sum33[31:0];
            end
            CMD_SUB: if (as1_op2 <= as1_op1) begin
                as_resp_c = RESP_OK;
                as_data_c = as1_op1 - as1_op2;
            end
            default: ;
        endcase
    end

    // Add/sub wins a collision; the shift result parks in the skid for one cycle.
    always_comb begin
        sel_v     = 1'b0;
        sel_resp  = 2'd0;
        sel_tag   = 2'd0;
        sel_data  = 32'd0;
        skid_load = 1'b0;
        if (as2_v) begin
            sel_v     = 1'b1;
            sel_resp  = as2_resp;
            sel_tag   = as2_tag;
            sel_data  = as2_data;
            skid_load = sh_v[3];
        end else if (skid_v) begin
            sel_v    = 1'b1;
            sel_resp = RESP_OK;
            sel_tag  = skid_tag;
            sel_data = skid_data;
        end else if (sh_v[3]) begin
            sel_v    = 1'b1;
            sel_resp = RESP_OK;
            sel_tag  = sh_tag[3];
            sel_data = sh_data[3];
        end
        busy_set = issue ? (4'b0001 << tag_q) : 4'b0000;
        busy_clr = sel_v ? (4'b0001 << sel_tag) : 4'b0000;
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cmd_q        <= 4'd0;
            tag_q        <= 2'd0;
            op1_q        <= 32'd0;
            busy         <= 4'd0;
            as1_v        <= 1'b0;
            as1_cmd      <= 4'd0;
            as1_tag      <= 2'd0;
            as1_op1      <= 32'd0;
            as1_op2      <= 32'd0;
            as2_v        <= 1'b0;
            as2_resp     <= 2'd0;
            as2_tag      <= 2'd0;
            as2_data     <= 32'd0;
            sh_v         <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                sh_tag[i]  <= 2'd0;
                sh_data[i] <= 32'd0;
            end
            skid_v       <= 1'b0;
            skid_tag     <= 2'd0;
            skid_data    <= 32'd0;
            bus.out_resp <= 2'd0;
            bus.out_data <= 32'd0;
            bus.out_tag  <= 2'd0;
            bus.tag_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.req_cmd_in != 4'd0) begin
                    cmd_q <= bus.req_cmd_in;
                    tag_q <= bus.req_tag_in;
                    op1_q <= bus.req_data_in;
                    state <= S_OP2;
                end
                S_OP2: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            bus.tag_err <= (state == S_OP2) && busy[tag_q];
            busy        <= (busy & ~busy_clr) | busy_set;

            as1_v   <= issue && !is_shift;
            as1_cmd <= cmd_q;
            as1_tag <= tag_q;
            as1_op1 <= op1_q;
            as1_op2 <= bus.req_data_in;
            as2_v    <= as1_v;
            as2_resp <= as_resp_c;
            as2_tag  <= as1_tag;
            as2_data <= as_data_c;

            sh_v       <= {sh_v[2:0], issue && is_shift};
            sh_tag[0]  <= tag_q;
            sh_data[0] <= shift_res;
            for (int i = 1; i < 4; i++) begin
                sh_tag[i]  <= sh_tag[i-1];
                sh_data[i] <= sh_data[i-1];
            end

            skid_v <= skid_load;
            if (skid_load) begin
                skid_tag  <= sh_tag[3];
                skid_data <= sh_data[3];
            end

            bus.out_resp <= sel_v ? sel_resp : 2'd0;
            bus.out_tag  <= sel_v ? sel_tag : 2'd0;
            bus.out_data <= (sel_v && sel_resp == RESP_OK) ? sel_data : 32'd0;
        end
    end
endmodule

// File: tb/tb_calc2_port_engine.sv
// Directed bench for calc2_port_engine: hand-computed responses are queued with the cycle they must appear in,
// and a negedge monitor checks every cycle's outputs against that queue.
module tb_calc2_port_engine;
    logic c_clk;
    logic reset;
    logic state_dbg;
    calc2_port_if bus ();

    calc2_port_engine dut (
        .c_clk     (c_clk),
        .reset     (reset),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_c = 0;
    logic mon_en = 1'b0;

    always @(posedge c_clk) cyc <= cyc + 1;

    // Scoreboard entry: {cycle[31:0], resp[1:0], tag[1:0], data[31:0]}
    logic [67:0] exp_q[$];
    int          te_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
        end
    endtask

    task automatic push_exp(input int at, input logic [1:0] resp, input logic [1:0] tag, input logic [31:0] data);
        logic [31:0] at32;
        at32 = at;
        exp_q.push_back({at32, resp, tag, data});
    endtask

    // Driver tasks
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge c_clk);
            bus.req_cmd_in  = 4'd0;
            bus.req_tag_in  = 2'd0;
            bus.req_data_in = 32'd0;
        end
    endtask

    task automatic send(input logic [3:0] cmd, input logic [1:0] tag, input logic [31:0] op1, input logic [31:0] op2);
        @(negedge c_clk);
        last_c = cyc;
        bus.req_cmd_in  = cmd;
        bus.req_tag_in  = tag;
        bus.req_data_in = op1;
        @(negedge c_clk);
        bus.req_cmd_in  = 4'hF;
        bus.req_tag_in  = 2'd3;
        bus.req_data_in = op2;
    endtask

    // Monitor
    always @(negedge c_clk) begin
        int idx;
        int te_idx;
        if (mon_en) begin
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++)
                if (exp_q[i][67:36] == cyc) idx = i;
            if (idx >= 0) begin
                check("resp", {30'd0, bus.out_resp}, {30'd0, exp_q[idx][35:34]});
                check("tag",  {30'd0, bus.out_tag},  {30'd0, exp_q[idx][33:32]});
                check("data", bus.out_data, exp_q[idx][31:0]);
                exp_q.delete(idx);
            end else begin
                check("no_resp", {30'd0, bus.out_resp}, 32'd0);
                check("no_data", bus.out_data, 32'd0);
            end
            te_idx = -1;
            for (int i = 0; i < te_q.size(); i++)
                if (te_q[i] == cyc) te_idx = i;
            check("tag_err", {31'd0, bus.tag_err}, {31'd0, te_idx >= 0});
            if (te_idx >= 0) te_q.delete(te_idx);
        end
    end

    initial begin
        reset = 1'b0;
        bus.req_cmd_in  = 4'd0;
        bus.req_tag_in  = 2'd0;
        bus.req_data_in = 32'd0;
        repeat (3) @(negedge c_clk);
        check("rst_resp", {30'd0, bus.out_resp}, 32'd0);
        check("rst_data", bus.out_data, 32'd0);
        check("rst_tag",  {30'd0, bus.out_tag}, 32'd0);
        check("rst_err",  {31'd0, bus.tag_err}, 32'd0);
        check("rst_state", {31'd0, state_dbg}, 32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;
        idle(5);

        // add success
        send(4'd1, 2'd1, 32'h30, 32'h20);
        push_exp(last_c + 4, 2'd1, 2'd1, 32'h50);
        idle(6);

        // error cases back to back, then a good subtract
        send(4'd1, 2'd2, 32'hFFFF_FFFF, 32'h1);
        push_exp(last_c + 4, 2'd2, 2'd2, 32'h0);
        send(4'd2, 2'd3, 32'h10, 32'h20);
        push_exp(last_c + 4, 2'd2, 2'd3, 32'h0);
        send(4'd4, 2'd0, 32'h1234, 32'h5678);
        push_exp(last_c + 4, 2'd2, 2'd0, 32'h0);
        idle(6);
        send(4'd2, 2'd0, 32'h20, 32'h10);
        push_exp(last_c + 4, 2'd1, 2'd0, 32'h10);
        idle(6);

        // shifts
        send(4'd5, 2'd1, 32'h1, 32'h21);
        push_exp(last_c + 6, 2'd1, 2'd1, 32'h2);
        send(4'd6, 2'd2, 32'h8000_0000, 32'd31);
        push_exp(last_c + 6, 2'd1, 2'd2, 32'h1);
        idle(8);

        // collision: shift then add two cycles later
        send(4'd5, 2'd0, 32'h3, 32'h4);
        push_exp(last_c + 7, 2'd1, 2'd0, 32'h30);
        send(4'd1, 2'd1, 32'd5, 32'd6);
        push_exp(last_c + 4, 2'd1, 2'd1, 32'hB);
        idle(8);

        // busy tag rejected
        send(4'd1, 2'd2, 32'h100, 32'h1);
        push_exp(last_c + 4, 2'd1, 2'd2, 32'h101);
        send(4'd2, 2'd2, 32'h5, 32'h3);
        te_q.push_back(last_c + 2);
        idle(8);

        // tag sampled again at the very edge its response is driven
        send(4'd1, 2'd3, 32'h7, 32'h8);
        push_exp(last_c + 4, 2'd1, 2'd3, 32'hF);
        idle(1);
        send(4'd2, 2'd3, 32'h9, 32'h4);
        push_exp(last_c + 4, 2'd1, 2'd3, 32'h5);
        idle(8);

        // reset during a pending shift discards it
        send(4'd6, 2'd1, 32'hF0, 32'h4);
        idle(2);
        reset = 1'b0;
        idle(2);
        check("mid_rst_state", {31'd0, state_dbg}, 32'd0);
        reset = 1'b1;
        idle(8);
        send(4'd1, 2'd1, 32'h1, 32'h2);
        push_exp(last_c + 4, 2'd1, 2'd1, 32'h3);
        idle(8);

        check("exp_left", exp_q.size(), 32'd0);
        check("te_left",  te_q.size(), 32'd0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
